// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: shifts a WIDTH-bit word out MSB-first with frame strobes.
// Optional trailing even-parity bit is built in when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             first;
  logic             accept;
  logic             last_bit;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  assign last_bit = (cnt == '0);

  always_comb begin
    state_nxt   = state;
    load_ready  = 1'b0;
    sout        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        load_ready = reset;
      end
      SHIFT: begin
        sout        = shreg[WIDTH-1];
        sout_valid  = 1'b1;
        frame_start = first;
        busy        = 1'b1;
        if (last_bit) begin
`ifdef PISO_PARITY_EN
          state_nxt  = PARITY;
`else
          frame_end  = 1'b1;
          load_ready = reset;
          state_nxt  = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        sout       = par_q;
        sout_valid = 1'b1;
        frame_end  = 1'b1;
        busy       = 1'b1;
        load_ready = reset;
        state_nxt  = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // A word taken on the final cycle of a frame starts the next one with no gap
    accept = load_valid & load_ready;
    if (accept) state_nxt = SHIFT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shreg <= din;
        cnt   <= CW'(WIDTH - 1);
        first <= 1'b1;
      end else if (state == SHIFT) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        cnt   <= cnt - 1'b1;
        first <= 1'b0;
      end
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      par_q <= 1'b0;
    else if (accept) par_q <= ^din;
  end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer; frame length follows PISO_PARITY_EN.
// Outputs are sampled on the falling edge, inputs driven there too.
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  // {sout, sout_valid, frame_start, frame_end, load_ready, busy}
  localparam logic [5:0] IDLE_V = 6'b000010;
  localparam logic [5:0] ZERO_V = 6'b000000;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_ready, sout, sout_valid, frame_start, frame_end, busy;
  logic [5:0]   obs;
  int           n_tests = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
    .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid),
    .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
  );

  assign obs = {sout, sout_valid, frame_start, frame_end, load_ready, busy};

  // Expected output vector for bit i (1-based) of a frame carrying word w
  function automatic logic [5:0] frame_bit(input logic [W-1:0] w, input int i);
    logic s;
    s = (i <= W) ? w[W-i] : ^w;
    return {s, 1'b1, (i == 1), (i == FL), (i == FL), 1'b1};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== ZERO_V) begin
        n_fail++;
        $display("FAIL reset_hold cycle=%0d got=%b exp=%b", c, obs, ZERO_V);
      end
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (obs !== IDLE_V) begin
      n_fail++;
      $display("FAIL reset_release got=%b exp=%b", obs, IDLE_V);
    end
    @(negedge clk);
    n_tests++;
    if (obs !== IDLE_V) begin
      n_fail++;
      $display("FAIL reset_idle got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    din = 8'hA5; load_valid = 1'b1;
    for (int i = 1; i <= FL; i++) begin
      @(negedge clk);
      if (i == 1) load_valid = 1'b0;
      n_tests++;
      if (obs !== frame_bit(8'hA5, i)) begin
        n_fail++;
        $display("FAIL single bit=%0d got=%b exp=%b", i, obs, frame_bit(8'hA5, i));
      end
    end
    @(negedge clk);
    n_tests++;
    if (obs !== IDLE_V) begin
      n_fail++;
      $display("FAIL single_after got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    din = 8'hA5; load_valid = 1'b1;
    for (int i = 1; i <= FL; i++) begin
      @(negedge clk);
      if (i == 1) din = 8'h3C;
      n_tests++;
      if (obs !== frame_bit(8'hA5, i)) begin
        n_fail++;
        $display("FAIL b2b_first bit=%0d got=%b exp=%b", i, obs, frame_bit(8'hA5, i));
      end
    end
    for (int i = 1; i <= FL; i++) begin
      @(negedge clk);
      if (i == 1) load_valid = 1'b0;
      n_tests++;
      if (obs !== frame_bit(8'h3C, i)) begin
        n_fail++;
        $display("FAIL b2b_second bit=%0d got=%b exp=%b", i, obs, frame_bit(8'h3C, i));
      end
    end
    @(negedge clk);
    n_tests++;
    if (obs !== IDLE_V) begin
      n_fail++;
      $display("FAIL b2b_after got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_ignored_load();
    @(negedge clk);
    din = 8'hA5; load_valid = 1'b1;
    for (int i = 1; i <= FL; i++) begin
      @(negedge clk);
      if (i == 1) load_valid = 1'b0;
      if (i == 2) begin din = 8'hFF; load_valid = 1'b1; end
      if (i == 6) load_valid = 1'b0;
      n_tests++;
      if (obs !== frame_bit(8'hA5, i)) begin
        n_fail++;
        $display("FAIL ignored_stream bit=%0d got=%b exp=%b", i, obs, frame_bit(8'hA5, i));
      end
    end
    @(negedge clk);
    n_tests++;
    if (obs !== IDLE_V) begin
      n_fail++;
      $display("FAIL ignored_not_taken got=%b exp=%b", obs, IDLE_V);
    end
    load_valid = 1'b1;
    for (int i = 1; i <= FL; i++) begin
      @(negedge clk);
      if (i == 1) load_valid = 1'b0;
      n_tests++;
      if (obs !== frame_bit(8'hFF, i)) begin
        n_fail++;
        $display("FAIL ignored_later bit=%0d got=%b exp=%b", i, obs, frame_bit(8'hFF, i));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    din = 8'hF0; load_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) load_valid = 1'b0;
      n_tests++;
      if (obs !== frame_bit(8'hF0, i)) begin
        n_fail++;
        $display("FAIL midrst_pre bit=%0d got=%b exp=%b", i, obs, frame_bit(8'hF0, i));
      end
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (obs !== ZERO_V) begin
      n_fail++;
      $display("FAIL midrst_async got=%b exp=%b", obs, ZERO_V);
    end
    @(negedge clk);
    n_tests++;
    if (obs !== ZERO_V) begin
      n_fail++;
      $display("FAIL midrst_hold got=%b exp=%b", obs, ZERO_V);
    end
    reset = 1'b1;
    din = 8'h81; load_valid = 1'b1;
    for (int i = 1; i <= FL; i++) begin
      @(negedge clk);
      if (i == 1) load_valid = 1'b0;
      n_tests++;
      if (obs !== frame_bit(8'h81, i)) begin
        n_fail++;
        $display("FAIL midrst_after bit=%0d got=%b exp=%b", i, obs, frame_bit(8'h81, i));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_parity();
    logic [W-1:0] words [2];
    words[0] = 8'hA5;
    words[1] = 8'h07;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      din = words[k]; load_valid = 1'b1;
      for (int i = 1; i <= FL; i++) begin
        @(negedge clk);
        if (i == 1) load_valid = 1'b0;
        n_tests++;
        if (obs !== frame_bit(words[k], i)) begin
          n_fail++;
          $display("FAIL parity word=%h bit=%0d got=%b exp=%b", words[k], i, obs,
                   frame_bit(words[k], i));
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored_load();
    test_reset_mid_frame();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
